branch_resolve_pc: RTL and testbench
====================================

Name: branch_resolve_pc

Overview:
- Consumes the 32-bit result of the comparison unit, together with decoded branch/jump information, and resolves control flow.
- Owns the architectural program-counter register that drives fetch.
- Generates redirect, flush and link-address outputs for the pipeline.
- Sits directly downstream of the comparison unit, on the execute-to-fetch feedback path.

Parameters:
- dataWidth, 32, width of PC, immediate, rs1 and compare result.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned-target trap.
- FLUSH_CYCLES, 2, number of cycles flush stays high after a redirect (legal range 1..7).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- res_valid  input  1  a control-flow instruction is presented for resolution.
- res_ready  output  1  block can accept a resolution this cycle.
- is_branch  input  1  conditional branch (BEQ/BNE/BLT/...).
- is_jal  input  1  JAL.
- is_jalr  input  1  JALR.
- compOut  input  dataWidth  comparison unit output; bit 0 = condition true, upper bits ignored.
- res_pc  input  dataWidth  PC of the resolving instruction.
- imm  input  dataWidth  sign-extended immediate.
- rs1_val  input  dataWidth  rs1 operand, used for JALR.
- stall  input  1  freeze sequential PC advance.
- pc  output  dataWidth  current fetch PC (registered).
- redirect  output  1  one-cycle pulse: pc was loaded with a non-sequential value.
- flush  output  1  squash younger in-flight instructions.
- link_addr  output  dataWidth  res_pc+4, registered.
- link_valid  output  1  one-cycle pulse: link_addr is valid for JAL/JALR writeback.
- trap  output  1  one-cycle pulse: misaligned target detected.

Behaviour:
- Reset (synchronous, sampled on rising clk):
  - pc=RESET_PC; state=RUN; flush counter=0.
  - redirect=0, flush=0, link_valid=0, trap=0, link_addr=0.
  - Reset asserted mid-flush aborts the flush immediately.
- States:
  - RUN: res_ready=1.
  - FLUSH: res_ready=0; res_valid is ignored and must be held by the upstream stage.
- Acceptance: a resolution is accepted when res_valid & res_ready; otherwise nothing resolves.
- Type priority when several flags are set: jalr > jal > branch. No flag set with res_valid=1 → treated as not-taken, no link.
- Target computation (all sums modulo 2^dataWidth, wrap-around silently):
  - branch/jal: res_pc+imm.
  - jalr: (rs1_val+imm) & ~1.
- Taken condition: jal | jalr | (branch & compOut[0]).
- Accepted and taken, target[1:0]==0:
  - Next cycle: pc=target, redirect=1.
  - Enter FLUSH with counter=FLUSH_CYCLES; flush is high while counter≠0 (exactly FLUSH_CYCLES cycles, starting the cycle redirect is high).
- Accepted and taken, target[1:0]≠0:
  - Next cycle: pc=TRAP_VECTOR, trap=1, redirect=1, enter FLUSH identically.
- Accepted and not taken: no redirect, no flush; pc advances by normal rules.
- Link: jal/jalr accepted → next cycle link_addr=res_pc+4, link_valid=1. Also applies when trapping.
- Sequential advance: when no redirect occurs, pc<=pc+4 if stall=0, else pc holds.
  - Redirect overrides stall.
  - During FLUSH, pc still advances from the target unless stalled.
- Counter: decrements every cycle in FLUSH regardless of stall. FLUSH→RUN when counter reaches 0; res_ready=1 in that same cycle.
- Latency: accept-to-pc-update is exactly 1 cycle. All outputs are registered except res_ready, which is decoded from state.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined:
  - Adds outputs branch_count[31:0] and taken_count[31:0], both reset to 0.
  - branch_count increments on every accepted resolution.
  - taken_count increments on every accepted taken resolution, traps included.
  - Both wrap from 32'hFFFF_FFFF to 0.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release: after reset → pc=0, all pulses 0, res_ready=1. Then 3 cycles with stall=0 → pc=0,4,8,C.
- Taken branch: is_branch, compOut=1, res_pc=0x20, imm=0x40 → next cycle pc=0x60, redirect=1, flush high 2 cycles, res_ready=0 for 2 cycles; a res_valid presented during FLUSH is not accepted.
- Not-taken branch: compOut=0x0000_0000 (also repeat with compOut=0xFFFF_FFFE) at res_pc=0x20 → no redirect/flush, pc continues +4.
- JALR: rs1_val=0x1001, imm=0x4, res_pc=0x80 → pc=0x1004, link_addr=0x84, link_valid=1, trap=0.
- Misaligned JAL: res_pc=0x10, imm=0x6 → pc=0x100, trap=1, link_valid=1, flush 2 cycles. Also: stall=1 throughout a taken branch → redirect still loads target, then pc holds.
- Reset mid-flush: assert reset one cycle after a redirect → next cycle pc=0, flush=0, res_ready=1. With BRANCH_STATS_EN defined, counters return to 0 and count 1 branch/1 taken after one further taken branch.

Source files
------------

// File: rtl/branch_resolve_pc.sv
// Branch/jump resolution and architectural fetch PC with post-redirect flush window.
// Optional macro BRANCH_STATS_EN adds accepted/taken resolution counters.
module branch_resolve_pc #(
  parameter int                   dataWidth    = 32,
  parameter logic [dataWidth-1:0] RESET_PC     = 32'h0000_0000,
  parameter logic [dataWidth-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int                   FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic                 is_branch,
  input  logic                 is_jal,
  input  logic                 is_jalr,
  input  logic [dataWidth-1:0] compOut,
  input  logic [dataWidth-1:0] res_pc,
  input  logic [dataWidth-1:0] imm,
  input  logic [dataWidth-1:0] rs1_val,
  input  logic                 stall,
  output logic [dataWidth-1:0] pc,
  output logic                 redirect,
  output logic                 flush,
  output logic [dataWidth-1:0] link_addr,
  output logic                 link_valid,
  output logic                 trap
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]          branch_count,
  output logic [31:0]          taken_count
`endif
);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [dataWidth-1:0] pc_q, pc_d;
  logic [dataWidth-1:0] link_addr_q, link_addr_d;
  logic                 redirect_q, redirect_d;
  logic                 flush_q, flush_d;
  logic                 link_valid_q, link_valid_d;
  logic                 trap_q, trap_d;

  logic                 accept, isLink, taken, misaligned;
  logic [dataWidth-1:0] jalrSum, target;
  logic                 unusedBits;

  assign res_ready  = (state_q == RUN);
  assign accept     = res_valid & res_ready;
  assign isLink     = is_jal | is_jalr;
  assign taken      = isLink | (is_branch & compOut[0]);
  assign jalrSum    = rs1_val + imm;
  // JALR wins over JAL/branch; JAL and branch share the PC-relative target
  assign target     = is_jalr ? {jalrSum[dataWidth-1:1], 1'b0} : (res_pc + imm);
  assign misaligned = (target[1:0] != 2'b00);
  assign unusedBits = ^{compOut[dataWidth-1:1], jalrSum[0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = stall ? pc_q : (pc_q + dataWidth'(4));
    redirect_d   = 1'b0;
    trap_d       = 1'b0;
    link_valid_d = 1'b0;
    link_addr_d  = link_addr_q;
    unique case (state_q)
      RUN: begin
        if (accept && taken) begin
          pc_d       = misaligned ? TRAP_VECTOR : target;
          redirect_d = 1'b1;
          trap_d     = misaligned;
          cnt_d      = 3'(FLUSH_CYCLES);
          state_d    = FLUSH;
        end
      end
      FLUSH: begin
        // Counter runs regardless of stall so the squash window has fixed length
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (accept && isLink) begin
      link_addr_d  = res_pc + dataWidth'(4);
      link_valid_d = 1'b1;
    end
    flush_d = (cnt_d != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= 3'd0;
      pc_q         <= RESET_PC;
      redirect_q   <= 1'b0;
      flush_q      <= 1'b0;
      link_valid_q <= 1'b0;
      trap_q       <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      flush_q      <= flush_d;
      link_valid_q <= link_valid_d;
      trap_q       <= trap_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign pc         = pc_q;
  assign redirect   = redirect_q;
  assign flush      = flush_q;
  assign link_valid = link_valid_q;
  assign trap       = trap_q;
  assign link_addr  = link_addr_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] branchCount_q, takenCount_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      branchCount_q <= 32'd0;
      takenCount_q  <= 32'd0;
    end else begin
      if (accept)          branchCount_q <= branchCount_q + 32'd1;
      if (accept && taken) takenCount_q  <= takenCount_q + 32'd1;
    end
  end

  assign branch_count = branchCount_q;
  assign taken_count  = takenCount_q;
`endif

endmodule

// File: tb/tb_branch_resolve_pc.sv
// Scoreboard bench for branch_resolve_pc: directed per-cycle vectors with hand-computed expectations.
module tb_branch_resolve_pc;

  typedef struct {
    logic        valid, br, jal, jalr, stall, rst;
    logic [31:0] comp, rpc, imm, rs1;
  } stim_t;

  typedef struct {
    int          when;
    logic [31:0] pc, la, bc, tc;
    logic        redirect, flush, lv, trap, ready;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, res_valid, is_branch, is_jal, is_jalr, stall;
  logic [31:0] compOut, res_pc, imm, rs1_val;
  logic        res_ready, redirect, flush, link_valid, trap;
  logic [31:0] pc, link_addr;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count, taken_count;
`endif

  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  branch_resolve_pc dut (
    .clk(clk), .reset(reset), .res_valid(res_valid), .res_ready(res_ready),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .compOut(compOut),
    .res_pc(res_pc), .imm(imm), .rs1_val(rs1_val), .stall(stall), .pc(pc),
    .redirect(redirect), .flush(flush), .link_addr(link_addr),
    .link_valid(link_valid), .trap(trap)
`ifdef BRANCH_STATS_EN
    , .branch_count(branch_count), .taken_count(taken_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic stim_t mkS(logic v, logic b, logic j, logic jr, logic [31:0] c,
                                logic [31:0] rp, logic [31:0] im, logic [31:0] r1,
                                logic st, logic rs);
    stim_t s;
    s.valid = v; s.br = b; s.jal = j; s.jalr = jr; s.comp = c; s.rpc = rp;
    s.imm = im; s.rs1 = r1; s.stall = st; s.rst = rs;
    return s;
  endfunction

  function automatic exp_t mkE(logic [31:0] p, logic rd, logic fl, logic lv, logic tr,
                               logic rdy, logic [31:0] la, logic [31:0] bc, logic [31:0] tc);
    exp_t e;
    e.when = 0; e.pc = p; e.redirect = rd; e.flush = fl; e.lv = lv; e.trap = tr;
    e.ready = rdy; e.la = la; e.bc = bc; e.tc = tc;
    return e;
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show after the next edge
  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    res_valid = s.valid; is_branch = s.br; is_jal = s.jal; is_jalr = s.jalr;
    compOut = s.comp; res_pc = s.rpc; imm = s.imm; rs1_val = s.rs1;
    stall = s.stall; reset = s.rst;
    e.when = cycle + 1;
    expQ.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("pc", pc, e.pc);
    cmp("redirect", 32'(redirect), 32'(e.redirect));
    cmp("flush", 32'(flush), 32'(e.flush));
    cmp("link_valid", 32'(link_valid), 32'(e.lv));
    cmp("trap", 32'(trap), 32'(e.trap));
    cmp("res_ready", 32'(res_ready), 32'(e.ready));
    cmp("link_addr", link_addr, e.la);
`ifdef BRANCH_STATS_EN
    cmp("branch_count", branch_count, e.bc);
    cmp("taken_count", taken_count, e.tc);
`endif
  endtask

  // Monitor: pops the expectation scheduled for this cycle, away from the active edge
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].when < cycle) begin
      checks++;
      errors++;
      $display("[TB] FAIL stale_expectation: scheduled cycle %0d, now %0d", expQ[0].when, cycle);
      void'(expQ.pop_front());
    end
    if (expQ.size() > 0 && expQ[0].when == cycle) checkOutput(expQ.pop_front());
  end

  initial begin
    stim_t idle, idleSt;
    reset = 1'b1; res_valid = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    compOut = '0; res_pc = '0; imm = '0; rs1_val = '0; stall = 1'b0;
    idle   = mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idleSt = mkS(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    $display("[TB] starting branch_resolve_pc scoreboard run");

    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mkE(32'h0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
    applyStimulus(idle, mkE(32'h4, 0, 0, 0, 0, 1, 32'h0, 0, 0));
    applyStimulus(idle, mkE(32'h8, 0, 0, 0, 0, 1, 32'h0, 0, 0));
    applyStimulus(idle, mkE(32'hC, 0, 0, 0, 0, 1, 32'h0, 0, 0));
    // Taken branch, then a resolution held during FLUSH that must not be accepted
    applyStimulus(mkS(1, 1, 0, 0, 1, 32'h20, 32'h40, 0, 0, 0), mkE(32'h60, 1, 1, 0, 0, 0, 32'h0, 1, 1));
    applyStimulus(mkS(1, 1, 0, 0, 1, 32'h20, 32'h100, 0, 0, 0), mkE(32'h64, 0, 1, 0, 0, 0, 32'h0, 1, 1));
    applyStimulus(mkS(1, 1, 0, 0, 1, 32'h20, 32'h100, 0, 0, 0), mkE(32'h68, 0, 0, 0, 0, 1, 32'h0, 1, 1));
    applyStimulus(idle, mkE(32'h6C, 0, 0, 0, 0, 1, 32'h0, 1, 1));
    // Not-taken branches: only compOut bit 0 matters
    applyStimulus(mkS(1, 1, 0, 0, 32'h0, 32'h20, 32'h40, 0, 0, 0), mkE(32'h70, 0, 0, 0, 0, 1, 32'h0, 2, 1));
    applyStimulus(mkS(1, 1, 0, 0, 32'hFFFF_FFFE, 32'h20, 32'h40, 0, 0, 0), mkE(32'h74, 0, 0, 0, 0, 1, 32'h0, 3, 1));
    // JALR clears bit 0 of rs1+imm
    applyStimulus(mkS(1, 0, 0, 1, 0, 32'h80, 32'h4, 32'h1001, 0, 0), mkE(32'h1004, 1, 1, 1, 0, 0, 32'h84, 4, 2));
    applyStimulus(idle, mkE(32'h1008, 0, 1, 0, 0, 0, 32'h84, 4, 2));
    applyStimulus(idle, mkE(32'h100C, 0, 0, 0, 0, 1, 32'h84, 4, 2));
    // Misaligned JAL traps but still links
    applyStimulus(mkS(1, 0, 1, 0, 0, 32'h10, 32'h6, 0, 0, 0), mkE(32'h100, 1, 1, 1, 1, 0, 32'h14, 5, 3));
    applyStimulus(idle, mkE(32'h104, 0, 1, 0, 0, 0, 32'h14, 5, 3));
    applyStimulus(idle, mkE(32'h108, 0, 0, 0, 0, 1, 32'h14, 5, 3));
    // Stall throughout a taken backward branch: redirect overrides stall, then pc holds
    applyStimulus(mkS(1, 1, 0, 0, 1, 32'h200, 32'hFFFF_FFF8, 0, 1, 0), mkE(32'h1F8, 1, 1, 0, 0, 0, 32'h14, 6, 4));
    applyStimulus(idleSt, mkE(32'h1F8, 0, 1, 0, 0, 0, 32'h14, 6, 4));
    applyStimulus(idleSt, mkE(32'h1F8, 0, 0, 0, 0, 1, 32'h14, 6, 4));
    applyStimulus(idleSt, mkE(32'h1F8, 0, 0, 0, 0, 1, 32'h14, 6, 4));
    // All flags set: JALR target rs1+imm wins over JAL/branch
    applyStimulus(mkS(1, 1, 1, 1, 0, 32'h40, 32'h10, 32'h300, 0, 0), mkE(32'h310, 1, 1, 1, 0, 0, 32'h44, 7, 5));
    // Reset one cycle after the redirect aborts the flush
    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mkE(32'h0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
    applyStimulus(idle, mkE(32'h4, 0, 0, 0, 0, 1, 32'h0, 0, 0));
    // No type flag: accepted as not-taken, no link
    applyStimulus(mkS(1, 0, 0, 0, 1, 32'h40, 32'h40, 0, 0, 0), mkE(32'h8, 0, 0, 0, 0, 1, 32'h0, 1, 0));
    // JAL target and link address wrap modulo 2^32
    applyStimulus(mkS(1, 0, 1, 0, 0, 32'hFFFF_FFF0, 32'h20, 0, 0, 0), mkE(32'h10, 1, 1, 1, 0, 0, 32'hFFFF_FFF4, 2, 1));
    applyStimulus(idle, mkE(32'h14, 0, 1, 0, 0, 0, 32'hFFFF_FFF4, 2, 1));
    applyStimulus(idle, mkE(32'h18, 0, 0, 0, 0, 1, 32'hFFFF_FFF4, 2, 1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
